// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, tag field offsets,
// execution-unit ids, the packet struct and the round-robin pointer advance.
// Ports: none (package).
package cdb_pkg;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 8;
  localparam int PKT_W  = TAG_W + DATA_W;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 2;

  // Tag field offsets within a full packet
  localparam int TAG_DST_LSB = 38;
  localparam int TAG_ID_LSB  = 32;

  // Requester index of each execution unit
  localparam int UNIT_ADD  = 0;
  localparam int UNIT_MULT = 1;
  localparam int UNIT_LOAD = 2;

  // Packet layout {tag, data}; tag = {dest reg, instruction id}
  typedef struct packed {
    logic [1:0]        dst;
    logic [5:0]        id;
    logic [DATA_W-1:0] data;
  } cdb_pkt_t;

  // Pointer position just after the granted index, wrapping at NREQ
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclic.
// Ports: req (request vector), ptr (search start) -> grant (one-hot), idx (encoded),
//        any_grant (some request set). No state, no clock.
module cdb_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_grant
);

  int c;

  // Scan from the farthest offset down to ptr itself so the nearest request wins.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    c         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        grant     = '0;
        grant[c]  = 1'b1;
        idx       = c[IW-1:0];
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit 1-entry skid buffers, round-robin grant of one
// buffered packet per cycle onto a registered result bus (no combinational bypass).
// Ports: clk, rst (async, active-high), flush (discard pending), req_valid/req_pkt/
//        req_ready (per-unit handshake), cdb_valid/cdb_pkt/cdb_src (result bus),
//        grant_cnt/stall_cnt (perf counters, built only with CDB_PERF_CNT_EN defined;
//        otherwise tied to zero).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NREQ_P = NREQ,
  parameter int CNT_P  = CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NREQ_P-1:0]       req_valid,
  input  logic [NREQ_P*PKT_W-1:0] req_pkt,
  output logic [NREQ_P-1:0]       req_ready,
  output logic                    cdb_valid,
  output logic [PKT_W-1:0]        cdb_pkt,
  output logic [IDX_W-1:0]        cdb_src,
  output logic [NREQ_P*CNT_P-1:0] grant_cnt,
  output logic [CNT_P-1:0]        stall_cnt
);

  logic [NREQ_P-1:0] buf_v;
  cdb_pkt_t          buf_pkt [NREQ_P];
  logic [IDX_W-1:0]  rr_ptr;
  cdb_pkt_t          cdb_q;

  logic [NREQ_P-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_grant;
  logic              do_grant;

  cdb_rr_pick #(.N(NREQ_P), .IW(IDX_W)) u_pick (
    .req       (buf_v),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (grant_idx),
    .any_grant (any_grant)
  );

  // Flush suppresses the grant so the pointer and bus do not advance that edge.
  assign do_grant  = any_grant & ~flush;
  // A buffer being drained this edge can be refilled on the same edge.
  assign req_ready = {NREQ_P{~flush}} & (~buf_v | grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v <= '0;
      for (int i = 0; i < NREQ_P; i++) buf_pkt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ_P; i++) begin
        if (flush) begin
          buf_v[i] <= 1'b0;
        end else if (req_valid[i] && req_ready[i]) begin
          buf_v[i]   <= 1'b1;
          buf_pkt[i] <= req_pkt[i*PKT_W +: PKT_W];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (do_grant) begin
      cdb_valid <= 1'b1;
      cdb_q     <= buf_pkt[grant_idx];
      cdb_src   <= grant_idx;
      rr_ptr    <= rr_next(grant_idx);
    end else begin
      // Packet and source hold on idle/flush cycles; only valid drops.
      cdb_valid <= 1'b0;
    end
  end

  assign cdb_pkt = cdb_q;

`ifdef CDB_PERF_CNT_EN
  logic [CNT_P-1:0] gcnt_q [NREQ_P];
  logic [CNT_P-1:0] stall_q;
  logic             stall_now;

  assign stall_now = |(req_valid & ~req_ready);

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ_P; i++) gcnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NREQ_P; i++) begin
        if (do_grant && grant[i] && (gcnt_q[i] != '1)) gcnt_q[i] <= gcnt_q[i] + 1'b1;
      end
      if (stall_now && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ_P; i++) grant_cnt[i*CNT_P +: CNT_P] = gcnt_q[i];
  end
  assign stall_cnt = stall_q;
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model of the buffers and round-robin policy.
// Ports: none (top-level bench).
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [2:0]   req_valid;
  logic [119:0] req_pkt;
  logic [2:0]   req_ready;
  logic         cdb_valid;
  logic [39:0]  cdb_pkt;
  logic [1:0]   cdb_src;
  logic [47:0]  grant_cnt;
  logic [15:0]  stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_pkt   (req_pkt),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_pkt   (cdb_pkt),
    .cdb_src   (cdb_src),
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_v [3];
  logic [39:0] m_p [3];
  int          m_rr;
  logic        m_cv;
  logic [39:0] m_cp;
  int          m_cs;
  int          m_g [3];
  int          m_st;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0; m_p[i] = '0; m_g[i] = 0;
    end
    m_rr = 0; m_cv = 1'b0; m_cp = '0; m_cs = 0; m_st = 0;
  endtask

  function automatic int m_pick();
    for (int k = 0; k < 3; k++) begin
      if (m_v[(m_rr + k) % 3]) return (m_rr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    int g;
    g = m_pick();
    for (int i = 0; i < 3; i++) r[i] = !flush && (!m_v[i] || g == i);
    return r;
  endfunction

  function automatic logic [47:0] exp_gcnt();
    logic [47:0] e;
    e = '0;
`ifdef CDB_PERF_CNT_EN
    for (int i = 0; i < 3; i++) e[i*16 +: 16] = 16'(m_g[i]);
`endif
    return e;
  endfunction

  function automatic logic [15:0] exp_stall();
`ifdef CDB_PERF_CNT_EN
    return 16'(m_st);
`else
    return 16'd0;
`endif
  endfunction

  // Advance model and DUT by one edge using the inputs currently driven.
  task automatic tick();
    int g;
    logic [2:0] rdy;
    g   = m_pick();
    rdy = m_ready();
    if ((req_valid & ~rdy) != 3'b000 && m_st < 65535) m_st++;
    if (flush) begin
      for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
      m_cv = 1'b0;
    end else begin
      if (g >= 0) begin
        m_cv = 1'b1; m_cp = m_p[g]; m_cs = g; m_v[g] = 1'b0; m_rr = (g + 1) % 3;
        if (m_g[g] < 65535) m_g[g]++;
      end else begin
        m_cv = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && rdy[i]) begin
          m_v[i] = 1'b1; m_p[i] = req_pkt[i*40 +: 40];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_pkt = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  function automatic logic [39:0] rnd_pkt();
    logic [39:0] p;
    p = {8'($urandom), 32'($urandom)};
    return p;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_pkt = '0;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", cdb_valid); end
    n_cmp++; if (cdb_pkt !== 40'h0) begin n_bad++; $display("FAIL reset_pkt got %h want 0", cdb_pkt); end
    n_cmp++; if (cdb_src !== 2'd0) begin n_bad++; $display("FAIL reset_src got %0d want 0", cdb_src); end
    n_cmp++; if (req_ready !== 3'b111) begin n_bad++; $display("FAIL reset_ready got %b want 111", req_ready); end
    n_cmp++; if (grant_cnt !== 48'h0 || stall_cnt !== 16'h0) begin
      n_bad++; $display("FAIL reset_cnt got %h/%h want 0/0", grant_cnt, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_single_add();
    do_reset();
    req_valid = 3'b001; req_pkt = '0; req_pkt[39:0] = 40'h40_00000057;
    tick();
    req_valid = 3'b000;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL add_no_bypass got %b want 0", cdb_valid); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_pkt !== 40'h40_00000057 || cdb_src !== 2'd0) begin
      n_bad++; $display("FAIL add_result got v=%b pkt=%h src=%0d want 1/4000000057/0", cdb_valid, cdb_pkt, cdb_src);
    end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0 || cdb_pkt !== 40'h40_00000057) begin
      n_bad++; $display("FAIL add_idle_hold got v=%b pkt=%h want 0/4000000057", cdb_valid, cdb_pkt);
    end
  endtask

  task automatic test_contention();
    int rdy_cnt [3];
    do_reset();
    for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;
    req_valid = 3'b111;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++) req_pkt[i*40 +: 40] = {6'(c), 2'(i), 32'($urandom)};
      #1;
      if (c > 0) for (int i = 0; i < 3; i++) rdy_cnt[i] += int'(req_ready[i]);
      tick();
      if (c > 0) begin
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'((c - 1) % 3) || cdb_pkt !== m_cp) begin
          n_bad++;
          $display("FAIL contention_seq cyc=%0d got v=%b src=%0d pkt=%h want 1/%0d/%h",
                   c, cdb_valid, cdb_src, cdb_pkt, (c - 1) % 3, m_cp);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rdy_cnt[i] != 3) begin n_bad++; $display("FAIL contention_ready req=%0d got %0d want 3", i, rdy_cnt[i]); end
    end
`ifdef CDB_PERF_CNT_EN
    n_cmp++; if (grant_cnt !== {16'd3, 16'd3, 16'd3}) begin
      n_bad++; $display("FAIL contention_gcnt got %h want 000300030003", grant_cnt);
    end
`endif
    n_cmp++; if (stall_cnt !== exp_stall()) begin
      n_bad++; $display("FAIL contention_stall got %0d want %0d", stall_cnt, exp_stall());
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [39:0] sent [$];
    logic [39:0] exp;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 3'b010 : 3'b000;
      req_pkt   = '0;
      req_pkt[79:40] = rnd_pkt();
      #1;
      if (c < 8) begin
        n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready cyc=%0d got 0 want 1", c); end
        sent.push_back(req_pkt[79:40]);
      end
      tick();
      if (c >= 1 && c <= 8) begin
        exp = sent.pop_front();
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_pkt !== exp || cdb_src !== 2'd1) begin
          n_bad++; $display("FAIL b2b_stream cyc=%0d got v=%b pkt=%h src=%0d want 1/%h/1", c, cdb_valid, cdb_pkt, cdb_src, exp);
        end
      end
    end
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", cdb_valid); end
  endtask

  task automatic test_flush();
    int exp_src [3];
    exp_src[0] = 1; exp_src[1] = 2; exp_src[2] = 0;
    do_reset();
    req_valid = 3'b001; req_pkt = {rnd_pkt(), rnd_pkt(), rnd_pkt()};
    tick();                                   // buffer 0 filled
    req_valid = 3'b101; req_pkt = {40'hAA_DEAD0002, rnd_pkt(), 40'hBB_DEAD0000};
    tick();                                   // grant 0 (ptr->1), refill 0, fill 2
    req_valid = 3'b000; flush = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL flush_ready got %b want 000", req_ready); end
    tick();
    flush = 1'b0;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", cdb_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost cyc=%0d got %b want 0", c, cdb_valid); end
    end
    // Pointer kept its post-grant value of 1 across the flush.
    req_valid = 3'b111; req_pkt = {rnd_pkt(), rnd_pkt(), rnd_pkt()};
    tick();
    req_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (cdb_valid !== 1'b1 || int'(cdb_src) != exp_src[c]) begin
        n_bad++; $display("FAIL flush_rrptr cyc=%0d got v=%b src=%0d want 1/%0d", c, cdb_valid, cdb_src, exp_src[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 3'b100; req_pkt = {40'hC3_12345678, 80'h0};
    tick();
    req_valid = 3'b000;
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_pkt !== 40'hC3_12345678) begin
      n_bad++; $display("FAIL arst_pre got v=%b pkt=%h want 1/c312345678", cdb_valid, cdb_pkt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0 || cdb_pkt !== 40'h0) begin
      n_bad++; $display("FAIL arst_immediate got v=%b pkt=%h want 0/0", cdb_valid, cdb_pkt);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (req_ready !== 3'b111) begin n_bad++; $display("FAIL arst_ready got %b want 111", req_ready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 3'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      req_pkt   = {rnd_pkt(), rnd_pkt(), rnd_pkt()};
      #1;
      n_cmp++; if (req_ready !== m_ready()) begin
        n_bad++; $display("FAIL rand_ready cyc=%0d got %b want %b", c, req_ready, m_ready());
      end
      tick();
      n_cmp++;
      if (cdb_valid !== m_cv || cdb_pkt !== m_cp || int'(cdb_src) != m_cs ||
          grant_cnt !== exp_gcnt() || stall_cnt !== exp_stall()) begin
        n_bad++;
        $display("FAIL rand_out cyc=%0d got v=%b pkt=%h src=%0d g=%h s=%0d want v=%b pkt=%h src=%0d g=%h s=%0d",
                 c, cdb_valid, cdb_pkt, cdb_src, grant_cnt, stall_cnt, m_cv, m_cp, m_cs, exp_gcnt(), exp_stall());
      end
    end
    flush = 1'b0; req_valid = '0;
  endtask

`ifdef CDB_PERF_CNT_EN
  task automatic test_saturation();
    do_reset();
    force dut.stall_q = 16'hFFFF;
    @(negedge clk);
    release dut.stall_q;
    m_st = 65535;
    req_valid = 3'b111; req_pkt = '0;
    tick();                                   // all accepted, no stall
    tick();                                   // stall cycle at saturation
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL stall_saturate got %h want ffff", stall_cnt);
    end
    req_valid = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
`ifdef CDB_PERF_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
